// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding, default widths and
// the NOP word that downstream stages substitute for squashed instructions.
package fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2,
      IDLE  = 2'd3
   } state_t;

   localparam int PC_WIDTH_DEF = 5;
   localparam int FCNT_WIDTH   = 3;
   localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Generic saturating up-counter with synchronous active-high reset.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner for the PIGRO pipeline: arbitrates redirect, stall and
// halt requests and opens a flush window after each redirect.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int PC_WIDTH     = PC_WIDTH_DEF,
   parameter int RESET_PC     = 0,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 jumpflag,
   input  logic [PC_WIDTH-1:0]  jump_dest,
   input  logic                 taken,
   input  logic [PC_WIDTH-1:0]  branch_dest,
   input  logic                 hazard,
   input  logic                 halt_req,
   input  logic                 resume,
   output logic [PC_WIDTH-1:0]  pc,
   output logic                 pc_valid,
   output logic                 flush,
   output logic                 stall,
   output logic [1:0]           state,
   output logic [CNT_WIDTH-1:0] redirect_cnt
);

   localparam logic [FCNT_WIDTH-1:0] FLUSH_LOAD = FCNT_WIDTH'(FLUSH_CYCLES);

   state_t                state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_d;
   logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
   logic                  redirect;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc;
      fcnt_d   = fcnt_q;
      redirect = 1'b0;
      stall    = 1'b0;
      case (state_q)
         IDLE: state_d = RUN;
         RUN: begin
            if (halt_req) begin
               state_d = HALT;
            end else if (jumpflag || taken) begin
               // jump outranks a simultaneous taken branch; counted once
               pc_d     = jumpflag ? jump_dest : branch_dest;
               state_d  = FLUSH;
               fcnt_d   = FLUSH_LOAD;
               redirect = 1'b1;
            end else if (hazard) begin
               stall = 1'b1;
            end else begin
               pc_d = pc + PC_WIDTH'(1);
            end
         end
         FLUSH: begin
            // requests seen here come from squashed instructions
            pc_d   = pc + PC_WIDTH'(1);
            fcnt_d = fcnt_q - FCNT_WIDTH'(1);
            if (fcnt_q <= FCNT_WIDTH'(1))
               state_d = RUN;
         end
         HALT: begin
            // the held pc was already fetched before halting, so resume moves on
            if (resume && !halt_req) begin
               state_d = RUN;
               pc_d    = pc + PC_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc      <= PC_WIDTH'(RESET_PC);
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pc      <= pc_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign pc_valid = (state_q == RUN) || (state_q == FLUSH);
   assign flush    = (state_q == FLUSH);
   assign state    = state_q;

   sat_counter #(.WIDTH(CNT_WIDTH)) u_redirect_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (redirect),
      .count (redirect_cnt)
   );

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that owns the program counter for the 5-stage PIGRO pipeline and sequences instruction fetch.
- Arbitrates between the redirect sources (jump, taken branch), the hazard stall and the halt/resume request, and produces the registered PC for the synchronous program memory.
- After any redirect it asserts a flush window that squashes the wrong-path instructions already in flight, so programs no longer need padding NOPs after JMP/BRQ.
- Sits between the decode/execute redirect logic and the program memory; replaces the ad-hoc PC update in the fetch stage.

Parameters:
- PC_WIDTH, 5, program counter width; the PC wraps modulo 2^PC_WIDTH.
- RESET_PC, 0, PC value loaded on reset.
- FLUSH_CYCLES, 2, number of fetch slots squashed after a redirect. Legal range 1..7.
- CNT_WIDTH, 8, width of the saturating redirect counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- jumpflag  in  1  jump request from execute.
- jump_dest  in  PC_WIDTH  jump target.
- taken  in  1  branch-taken request from execute.
- branch_dest  in  PC_WIDTH  branch target.
- hazard  in  1  RAW stall request from decode; holds the PC.
- halt_req  in  1  enter HALT; level-sensitive.
- resume  in  1  leave HALT; pulse.
- pc  out  PC_WIDTH  registered fetch address to the program memory.
- pc_valid  out  1  pc is a live fetch address this cycle.
- flush  out  1  the instruction leaving fetch this cycle is wrong-path; downstream must replace it with a NOP.
- stall  out  1  pc is held this cycle because of hazard.
- state  out  2  FSM state, for debug.
- redirect_cnt  out  CNT_WIDTH  number of redirects taken, saturating.

Behaviour:
- State encoding, to live in the package: RUN=0, FLUSH=1, HALT=2, IDLE=3.
- Reset, synchronous with rst=1 at a clock edge, takes priority over everything else:
  - pc=RESET_PC, state=IDLE, pc_valid=0, flush=0, stall=0, redirect_cnt=0, flush counter=0.
  - This applies mid-FLUSH and mid-HALT as well: all state is cleared.
- IDLE: lasts exactly one cycle after reset is released, then goes to RUN. The PC is not incremented in IDLE, so RESET_PC is the first address fetched.
- RUN: per-cycle next-PC priority, highest first:
  1. halt_req → HALT. PC held.
  2. jumpflag → pc=jump_dest, enter FLUSH with flush counter=FLUSH_CYCLES.
  3. taken → pc=branch_dest, enter FLUSH with flush counter=FLUSH_CYCLES.
  4. hazard → PC held, stall=1.
  5. Otherwise pc=pc+1, wrapping from 31 to 0.
- Simultaneous jumpflag and taken: the jump wins; branch_dest is ignored; redirect_cnt increments by 1, not 2.
- FLUSH:
  - flush=1 in every FLUSH cycle.
  - pc increments from the target each cycle.
  - jumpflag, taken and hazard are ignored, because they originate from squashed instructions.
  - The flush counter decrements each cycle; when it reaches 1, the next state is RUN.
  - halt_req is honoured only after FLUSH completes.
- Latency:
  - The redirect request is sampled at edge N; pc=target is visible after edge N.
  - Program memory data for the target arrives after edge N+1.
  - flush is high after edges N through N+FLUSH_CYCLES-1, i.e. for exactly FLUSH_CYCLES cycles.
- HALT:
  - pc_valid=0; pc frozen; flush=0; stall=0.
  - A resume pulse returns to RUN on the next edge, but only if halt_req=0; otherwise the block stays in HALT.
  - Redirect requests arriving in HALT are dropped.
- Outputs:
  - pc_valid=1 in RUN and FLUSH.
  - stall is combinational from hazard, and only in RUN with no higher-priority request.
  - All other outputs are registered.
- redirect_cnt increments once per accepted redirect and saturates at 2^CNT_WIDTH-1.
- Wrap-around: a jump target of 31 followed by an increment gives pc=0. No error is raised.

Decomposition:
- Shared package/include (alongside opcodes.vh): state encodings, PC_WIDTH default, NOP encoding used for squashing.
- One sub-module, sat_counter: a generic saturating up-counter with synchronous reset, used for redirect_cnt.

Test Plan:
- Reset then free run: rst high for 2 cycles, then low → state IDLE for 1 cycle, pc sequence 0,1,2,…; after 32 increments pc=0 (wrap).
- Jump: at pc=19 pulse jumpflag with jump_dest=15 → next pc=15, then 16, 17; flush high for exactly 2 cycles; redirect_cnt=1.
- Simultaneous requests: jumpflag=1 with jump_dest=4, taken=1 with branch_dest=23 → pc=4; redirect_cnt increments by 1.
- Redirect during FLUSH: taken=1 with branch_dest=23 one cycle after a jump to 15 → ignored; pc=16, then 17; state returns to RUN.
- Hazard: hazard high for 3 cycles at pc=11 → pc stays 11 for 3 cycles with stall=1, then moves to 12. Hazard during FLUSH leaves stall=0 and pc advancing.
- Halt and reset: halt_req at pc=7 → pc_valid=0, pc frozen at 7; resume with halt_req=0 → pc 8. A separate run asserting rst mid-FLUSH → pc=0, flush=0, state IDLE next cycle.
